// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the decode-stage immediate generator.
// Immediate format select codes and their encoding width.
package imm_gen_stage_pkg;

  localparam int IMM_OP_W = 3;

  typedef enum logic [IMM_OP_W-1:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_Z     = 3'd6,
    IMM_NONE  = 3'd7
  } imm_op_e;

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational immediate extraction: (inst, op) -> XLEN-wide immediate.
// Every format is first built at 64 bits and then truncated to XLEN, so the
// same expressions serve XLEN=32 and XLEN=64.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          inst,
  input  logic [IMM_OP_W-1:0]  op,
  output logic [XLEN-1:0]      imm
);

  logic [63:0] wide;
  logic        unused_bits;

  // Opcode bits and the upper half of the 64-bit form are not needed for XLEN=32.
  assign unused_bits = ^{inst[6:0], wide};

  // Select and extend the immediate field for the requested format.
  always_comb begin
    wide = '0;
    case (imm_op_e'(op))
      IMM_I:     wide = {{52{inst[31]}}, inst[31:20]};
      IMM_S:     wide = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     wide = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     wide = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:     wide = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_SHAMT: begin
        if (XLEN == 64) wide = {58'd0, inst[25:20]};
        else            wide = {59'd0, inst[24:20]};
      end
      IMM_Z:     wide = {59'd0, inst[19:15]};
      IMM_NONE:  wide = '0;
      default:   wide = '0;
    endcase
    imm = wide[XLEN-1:0];
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage with valid/ready on both sides.
// Build option IMM_GEN_SKID_EN: adds a second (skid) entry and makes in_ready
// a pure register; otherwise a single entry with combinational in_ready.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; valid never depends on ready, held data is stable while valid && !ready,
// and flush at an edge overrides every transfer on both sides.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [IMM_OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag
);

  logic [XLEN-1:0]  dec_imm;
  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             accept;
  logic             consume;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .inst (in_inst),
    .op   (in_op),
    .imm  (dec_imm)
  );

  assign accept    = in_valid && in_ready && !flush;
  assign consume   = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_imm   = main_imm;
  assign out_tag   = main_tag;

`ifdef IMM_GEN_SKID_EN
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;

  // Ready only looks at our own register, so no path from out_ready.
  assign in_ready = !skid_valid;

  // Main/skid storage: skid only fills while main is held, and refills main on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        main_imm   <= skid_imm;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_imm <= dec_imm;
        main_tag <= in_tag;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_valid <= 1'b1;
        skid_imm   <= dec_imm;
        skid_tag   <= in_tag;
      end else begin
        main_valid <= 1'b1;
        main_imm   <= dec_imm;
        main_tag   <= in_tag;
      end
    end
  end
`else
  // Single entry: can take a beat when empty or when the held one leaves now.
  assign in_ready = !main_valid || out_ready;

  // Single-entry storage; an accept in the same cycle as a consume replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_imm   <= dec_imm;
      main_tag   <= in_tag;
    end else if (consume) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate generator for the decode stage of the RISC-V pipeline. It takes a raw 32-bit instruction and an immediate-format select and produces a correctly sign- or zero-extended XLEN-wide immediate, plus a passthrough sideband tag such as the PC. Input and output use valid/ready handshakes, with flush support and an optional two-entry skid buffer, so the block sits between fetch/IF-ID and the register-read stage without combinational ready paths.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- TAG_W, 32, width of the sideband carried alongside each immediate.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discards all held and incoming beats.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_inst  in  32  raw instruction word.
- in_op  in  3  immediate format select.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  sideband of the same beat.

## Operation
- Format ops are IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_SHAMT=5, IMM_Z=6, IMM_NONE=7.
- IMM_I: sext(inst[31:20]).
- IMM_S: sext({inst[31:25],inst[11:7]}).
- IMM_B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
- IMM_U: sext({inst[31:12],12'b0}). For XLEN=64, bit 31 fills bits 63:32.
- IMM_J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
- IMM_SHAMT: zext(inst[24:20]) when XLEN=32; zext(inst[25:20]) when XLEN=64.
- IMM_Z: zext(inst[19:15]), the CSR uimm.
- IMM_NONE: zero.
- sext means replicate the extracted field's MSB up to bit XLEN-1. zext fills with zeros.
- A beat is accepted when in_valid && in_ready at a rising edge. The immediate is computed combinationally from in_inst/in_op and captured together with in_tag.
- A beat leaves when out_valid && out_ready at a rising edge.
- Order is strict FIFO. No beat is ever duplicated or dropped except by flush.
- flush high at an edge: all held entries invalidated, and any beat offered in the same cycle is discarded (not accepted). flush has priority over all handshakes.
- in_op and in_inst are don't-care when in_valid is low.
- rst_n low: out_valid=0, out_imm=0, out_tag=0, all entries invalid. Reset mid-transfer loses held beats with no further side effect.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is presented on out_* from edge N onward until consumed.
- Throughput: 1 beat/cycle while out_ready stays high.
- out_imm and out_tag are stable while out_valid && !out_ready.
- With skid:
  - in_ready is a pure register: in_ready = !skid_valid. It reads 1 out of reset.
  - Main full, out_ready low, new beat accepted: the beat goes to the skid entry and in_ready falls at the next edge.
  - When main drains, skid moves to main and in_ready rises one cycle later.
  - Simultaneous accept and consume with skid empty: main is replaced with no bubble.
- Without skid:
  - in_ready = !out_valid || out_ready (combinational).
- In both modes, the cycle after flush: out_valid=0 and in_ready=1.

## Configuration
- IMM_GEN_SKID_EN defined: two storage entries (main + skid) and fully registered in_ready, as above.
- IMM_GEN_SKID_EN undefined: a single entry, and in_ready depends combinationally on out_ready.
- Data behaviour, latency and flush semantics are identical in both modes; only the ready path and depth differ.

## Structure
- The op-code constants (IMM_I … IMM_NONE) and IMM_OP_W=3 go in the shared param.vh header next to the existing sign-extension op defines.
- Sub-module imm_decode is purely combinational: (inst, op) -> XLEN immediate, parametrised by XLEN.
- imm_gen_stage holds only the handshake and storage logic.

## Test plan
- XLEN=32, in_op=IMM_I, in_inst=0xFFF00093 (addi x1,x0,-1) -> out_imm=0xFFFFFFFF one cycle after acceptance, out_tag echoed.
- XLEN=32, in_op=IMM_B, in_inst=0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC.
- XLEN=64, in_op=IMM_U, in_inst=0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000. Same instruction with IMM_SHAMT on 0x03F09093 (slli x1,x1,63) -> 0x000000000000003F.
- Skid enabled:
  - Stimulus: out_ready held low for 3 cycles while beats with tags 1, 2, 3 are offered back-to-back.
  - Response: tags 1 and 2 accepted, in_ready=0 for tag 3. When out_ready rises, tags emerge in order 1, 2, 3 with no gaps or loss.
- Both entries full, then flush pulsed with in_valid=1 (tag 9) -> out_valid=0 next cycle, in_ready=1, and tag 9 never appears.
- rst_n asserted asynchronously while out_valid=1 mid-stream -> out_valid, out_imm and out_tag go to 0 immediately, without waiting for a clock edge. The first beat after release appears with 1-cycle latency.
